// File: rtl/i2c_cmd_master_pkg.sv
// Shared definitions for the I2C command master: FSM state codes, quarter-bit
// phase codes and the transaction length helper.
package i2c_cmd_pkg;

    typedef logic [2:0] stateT;

    localparam stateT IDLE  = 3'd0;
    localparam stateT START = 3'd1;
    localparam stateT BIT   = 3'd2;
    localparam stateT ACKS  = 3'd3;
    localparam stateT STOP  = 3'd4;
    localparam stateT DONE  = 3'd5;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Quarter-bit ticks from accept to DONE; a negative or out-of-range
    // nackByte means every byte was acknowledged.
    function automatic int tickCount(input int nBytes, input int nackByte);
        if (nackByte < 0 || nackByte >= nBytes)
            return 8 + 36 * nBytes;
        return 8 + 36 * (nackByte + 1);
    endfunction

endpackage

// File: rtl/i2c_cmd_master_if.sv
// Command handshake between the configuration sequencer and the I2C master.
interface i2c_cmd_master_if #(
    parameter int NBYTES = 3
);
    logic [8*NBYTES-1:0] iDATA;
    logic                iGO;
    logic                oBUSY;
    logic                oEND;
    logic                oACK;

    modport master (input iDATA, input iGO, output oBUSY, output oEND, output oACK);
    modport slave  (output iDATA, output iGO, input oBUSY, input oEND, input oACK);
endinterface

// File: rtl/i2c_cmd_master_tick_gen.sv
// Quarter-bit clock enable: one-cycle tick every DIV cycles plus a 2-bit
// quarter index; both are held at zero while hold is asserted.
module i2c_tick_gen #(
    parameter int DIV = 625
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       hold,
    output logic       tick,
    output logic [1:0] quarter
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] divCnt;

    assign tick = !hold && (divCnt == CW'(DIV - 1));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            divCnt  <= '0;
            quarter <= 2'd0;
        end else if (hold) begin
            divCnt  <= '0;
            quarter <= 2'd0;
        end else if (tick) begin
            divCnt  <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            divCnt  <= divCnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_cmd_master.sv
// Byte-level I2C write master: sends NBYTES latched bytes MSB-first between a
// START and a STOP, aborting early on a NACK.
module i2c_cmd_master
    import i2c_cmd_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000,
    parameter int NBYTES   = 3
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    i2c_cmd_master_if.master     cmd,
    output logic                 I2C_SCLK,
    inout  wire                  I2C_SDAT
);
    localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int SW  = 8 * NBYTES;
    localparam int BW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    stateT          state;
    logic [SW-1:0]  shiftReg;
    logic [2:0]     bitCnt;
    logic [BW-1:0]  byteCnt;
    logic           sclReg;
    logic           sdaLow;
    logic           busyReg;
    logic           endReg;
    logic           nackReg;
    logic           tick;
    logic [1:0]     quarter;

    i2c_tick_gen #(.DIV(DIV)) tickGen (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .hold    ((state == IDLE) || (state == DONE)),
        .tick    (tick),
        .quarter (quarter)
    );

    assign I2C_SCLK  = sclReg;
    assign I2C_SDAT  = sdaLow ? 1'b0 : 1'bz;
    assign cmd.oBUSY = busyReg;
    assign cmd.oEND  = endReg;
    assign cmd.oACK  = nackReg;

    // Bus phases advance only on ticks; the handshake states react every cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitCnt   <= 3'd0;
            byteCnt  <= '0;
            sclReg   <= 1'b1;
            sdaLow   <= 1'b0;
            busyReg  <= 1'b0;
            endReg   <= 1'b0;
            nackReg  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd.iGO) begin
                    shiftReg <= cmd.iDATA;
                    busyReg  <= 1'b1;
                    nackReg  <= 1'b0;
                    bitCnt   <= 3'd0;
                    byteCnt  <= '0;
                    state    <= START;
                end
                START: if (tick) begin
                    case (quarter)
                        Q0: begin sdaLow <= 1'b0; sclReg <= 1'b1; end
                        Q1: sdaLow <= 1'b1;
                        Q2: sclReg <= 1'b0;
                        default: state <= BIT;
                    endcase
                end
                BIT: if (tick) begin
                    case (quarter)
                        Q0: begin sdaLow <= !shiftReg[SW-1]; sclReg <= 1'b0; end
                        Q1: sclReg <= 1'b1;
                        Q3: begin
                            sclReg   <= 1'b0;
                            shiftReg <= {shiftReg[SW-2:0], 1'b0};
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) state <= ACKS;
                        end
                        default: ;
                    endcase
                end
                ACKS: if (tick) begin
                    case (quarter)
                        Q0: sdaLow <= 1'b0;
                        Q1: sclReg <= 1'b1;
                        Q2: if (I2C_SDAT) nackReg <= 1'b1;
                        default: begin
                            sclReg <= 1'b0;
                            // A NACK skips whatever bytes are still queued.
                            if (!nackReg && byteCnt != BW'(NBYTES - 1)) begin
                                byteCnt <= byteCnt + 1'b1;
                                state   <= BIT;
                            end else begin
                                state   <= STOP;
                            end
                        end
                    endcase
                end
                STOP: if (tick) begin
                    case (quarter)
                        Q0: sdaLow <= 1'b1;
                        Q1: sclReg <= 1'b1;
                        Q2: sdaLow <= 1'b0;
                        default: begin state <= DONE; endReg <= 1'b1; end
                    endcase
                end
                DONE: if (!cmd.iGO) begin
                    state   <= IDLE;
                    endReg  <= 1'b0;
                    busyReg <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
